// File: rtl/conv_256_pe.sv
// conv_256_pe: NUM_OF_PE independent signed MAC processing elements sharing one
// broadcast weight. Each PE accumulates IFM_i * Weight every cycle unless it is
// restarted (cleared) or finished (frozen, result flagged valid).
// Optional build macro CONV256_RELU_EN: OFM uses a ReLU clamp to 0..127 instead
// of signed saturation to -128..127. Accumulator, valid and timing are unchanged.
module conv_256_pe #(
    parameter int NUM_OF_PE = 256,
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 24
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_OF_PE*DATA_W-1:0]   IFM,
    input  logic [DATA_W-1:0]             Weight,
    output logic [NUM_OF_PE*DATA_W-1:0]   OFM,
    input  logic [NUM_OF_PE-1:0]          PE_restart,
    input  logic [NUM_OF_PE-1:0]          PE_finish,
    output logic [NUM_OF_PE-1:0]          valid
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [DATA_W-1:0]       OUT_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
`ifndef CONV256_RELU_EN
    localparam logic [DATA_W-1:0]       OUT_MIN = {1'b1, {(DATA_W - 1){1'b0}}};
`endif

    logic signed [2*DATA_W-1:0] prod  [NUM_OF_PE];
    logic signed [ACC_W-1:0]    acc_d [NUM_OF_PE];
    logic signed [ACC_W-1:0]    acc_q [NUM_OF_PE];
    logic [NUM_OF_PE-1:0]       valid_d;
    logic [NUM_OF_PE-1:0]       valid_q;

    // Per-PE next accumulator: restart clears, finish holds, otherwise MAC.
    always_comb begin
        for (int unsigned i = 0; i < NUM_OF_PE; i++) begin
            prod[i]  = $signed(IFM[i*DATA_W +: DATA_W]) * $signed(Weight);
            acc_d[i] = acc_q[i];
            if (PE_restart[i]) begin
                acc_d[i] = '0;
            end else if (!PE_finish[i]) begin
                acc_d[i] = acc_q[i] + ACC_W'(prod[i]);
            end
        end
    end

    // Result is final only while finish is held and not overridden by restart.
    always_comb begin
        valid_d = PE_finish & ~PE_restart;
    end

    // Accumulator and valid registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q   <= '{default: '0};
            valid_q <= '0;
        end else begin
            acc_q   <= acc_d;
            valid_q <= valid_d;
        end
    end

    assign valid = valid_q;

    // Map each accumulator onto an output byte (saturation or ReLU clamp).
    always_comb begin
        OFM = '0;
        for (int unsigned i = 0; i < NUM_OF_PE; i++) begin
`ifdef CONV256_RELU_EN
            if (acc_q[i][ACC_W-1]) begin
                OFM[i*DATA_W +: DATA_W] = '0;
            end else if (acc_q[i] > SAT_MAX) begin
                OFM[i*DATA_W +: DATA_W] = OUT_MAX;
            end else begin
                OFM[i*DATA_W +: DATA_W] = acc_q[i][DATA_W-1:0];
            end
`else
            if (acc_q[i] > SAT_MAX) begin
                OFM[i*DATA_W +: DATA_W] = OUT_MAX;
            end else if (acc_q[i] < SAT_MIN) begin
                OFM[i*DATA_W +: DATA_W] = OUT_MIN;
            end else begin
                OFM[i*DATA_W +: DATA_W] = acc_q[i][DATA_W-1:0];
            end
`endif
        end
    end

endmodule

// File: tb/tb_conv_256_pe.sv
// tb_conv_256_pe: directed stimulus with a cycle-tagged scoreboard for conv_256_pe.
// Stimulus pushes expected OFM/valid vectors; a negedge monitor pops and compares.
module tb_conv_256_pe;

    localparam int N = 256;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N*8-1:0]   IFM;
    logic [7:0]       Weight;
    logic [N*8-1:0]   OFM;
    logic [N-1:0]     PE_restart;
    logic [N-1:0]     PE_finish;
    logic [N-1:0]     valid;

    conv_256_pe #(.NUM_OF_PE(N), .DATA_W(8), .ACC_W(24)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .IFM        (IFM),
        .Weight     (Weight),
        .OFM        (OFM),
        .PE_restart (PE_restart),
        .PE_finish  (PE_finish),
        .valid      (valid)
    );

    always #5 clk = ~clk;

`ifdef CONV256_RELU_EN
    localparam logic [7:0] EXP_NEG128 = 8'h00;
    localparam logic [7:0] EXP_NEG3   = 8'h00;
`else
    localparam logic [7:0] EXP_NEG128 = 8'h80;
    localparam logic [7:0] EXP_NEG3   = 8'hFD;
`endif

    typedef struct {
        int unsigned    cyc;
        string          name;
        logic [N*8-1:0] ofm;
        logic [N-1:0]   vld;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          bad_pe;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation tagged for the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if (mon_e.cyc != cyc || OFM !== mon_e.ofm || valid !== mon_e.vld) begin
                errors++;
                bad_pe = 0;
                for (int i = N - 1; i >= 0; i--)
                    if (OFM[i*8 +: 8] !== mon_e.ofm[i*8 +: 8] || valid[i] !== mon_e.vld[i])
                        bad_pe = i;
                $display("FAIL %s (cyc %0d, due %0d): PE %0d ofm=%h valid=%b, expected ofm=%h valid=%b",
                         mon_e.name, cyc, mon_e.cyc, bad_pe, OFM[bad_pe*8 +: 8], valid[bad_pe],
                         mon_e.ofm[bad_pe*8 +: 8], mon_e.vld[bad_pe]);
            end
        end
    end

    function automatic logic [N*8-1:0] rep(input logic [7:0] b);
        return {N{b}};
    endfunction

    task automatic drive(input logic [7:0] ib, input logic [7:0] w,
                         input logic [N-1:0] rs, input logic [N-1:0] fn, input logic rn);
        @(negedge clk);
        IFM        = {N{ib}};
        Weight     = w;
        PE_restart = rs;
        PE_finish  = fn;
        reset_n    = rn;
    endtask

    // Expectation for the negedge following the edge that consumes the last drive.
    task automatic expect_vec(input string name, input logic [N*8-1:0] o, input logic [N-1:0] v);
        exp_t e;
        e.cyc  = cyc + 1;
        e.name = name;
        e.ofm  = o;
        e.vld  = v;
        sb.push_back(e);
    endtask

    task automatic macs(input int n, input logic [7:0] ib, input logic [7:0] w);
        for (int k = 0; k < n; k++) drive(ib, w, '0, '0, 1'b1);
    endtask

    logic [N*8-1:0] ev;
    logic [N-1:0]   one_pe;

    initial begin
        reset_n = 1'b0; IFM = '0; Weight = '0; PE_restart = '0; PE_finish = '0;

        // Reset with random data and controls.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int w = 0; w < N / 4; w++) begin
                IFM[w*32 +: 32]        = $urandom;
                PE_restart[w*4 +: 4]   = 4'($urandom);
                PE_finish[w*4 +: 4]    = 4'($urandom);
            end
            Weight  = 8'($urandom);
            reset_n = 1'b0;
            expect_vec("reset", '0, '0);
        end

        // Restart all, then 27 MACs of 1x2.
        drive(8'h01, 8'h02, '1, '0, 1'b1);
        expect_vec("restart_all", '0, '0);
        macs(1, 8'h01, 8'h02);
        expect_vec("first_mac", rep(8'h02), '0);
        macs(26, 8'h01, 8'h02);
        expect_vec("sum27_1x2", rep(8'h36), '0);

        // Restart PE0 alone mid-accumulation.
        drive(8'h01, 8'h02, '1, '0, 1'b1);
        macs(10, 8'h01, 8'h02);
        expect_vec("ten_macs", rep(8'h14), '0);
        one_pe = N'(1);
        drive(8'h01, 8'h02, one_pe, '0, 1'b1);
        ev = rep(8'h16); ev[7:0] = 8'h00;
        expect_vec("restart_pe0", ev, '0);
        macs(27, 8'h01, 8'h02);
        ev = rep(8'h4C); ev[7:0] = 8'h36;
        expect_vec("pe0_fresh_sum", ev, '0);

        // Finish all for 3 cycles with toggling operands, then release.
        drive(8'h01, 8'h02, '1, '0, 1'b1);
        macs(5, 8'h01, 8'h02);
        for (int c = 0; c < 3; c++) begin
            drive(8'($urandom), 8'($urandom), '0, '1, 1'b1);
            expect_vec("finish_hold", rep(8'h0A), '1);
        end
        drive(8'h00, 8'h00, '0, '0, 1'b1);
        expect_vec("finish_release", rep(8'h0A), '0);

        // Restart+finish on PE5 (restart wins), finish only on PE7.
        drive(8'h01, 8'h02, '1, '0, 1'b1);
        macs(3, 8'h01, 8'h02);
        drive(8'h01, 8'h02, N'(1) << 5, (N'(1) << 5) | (N'(1) << 7), 1'b1);
        ev = rep(8'h08); ev[5*8 +: 8] = 8'h00; ev[7*8 +: 8] = 8'h06;
        expect_vec("restart_beats_finish", ev, N'(1) << 7);

        // Positive saturation.
        drive(8'h7F, 8'h7F, '1, '0, 1'b1);
        macs(27, 8'h7F, 8'h7F);
        expect_vec("sat_pos", rep(8'h7F), '0);

        // Signed product: (-128)*(-128) is positive.
        drive(8'h00, 8'h00, '1, '0, 1'b1);
        macs(1, 8'h80, 8'h80);
        expect_vec("neg_times_neg", rep(8'h7F), '0);

        // Small negative result: (-1)*3.
        drive(8'h00, 8'h00, '1, '0, 1'b1);
        macs(1, 8'hFF, 8'h03);
        expect_vec("small_negative", rep(EXP_NEG3), '0);

        // Negative saturation / ReLU clamp.
        drive(8'h00, 8'h00, '1, '0, 1'b1);
        macs(27, 8'h80, 8'h01);
        expect_vec("sat_neg", rep(EXP_NEG128), '0);

        // Reset mid-accumulation overrides finish.
        drive(8'h55, 8'h33, '0, '1, 1'b0);
        expect_vec("reset_mid", '0, '0);
        macs(1, 8'h01, 8'h02);
        expect_vec("after_reset_mac", rep(8'h02), '0);

        // Drain scoreboard with a bounded wait.
        for (int c = 0; c < 10 && sb.size() > 0; c++) @(negedge clk);
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations pending, required 0", sb.size());
            checks += sb.size();
            errors += sb.size();
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_256_pe.md
CONV_256_PE -- requirements
Module: conv_256_pe

Interface
REQ-001 Parameter NUM_OF_PE, default 256; number of parallel MAC processing elements (PEs).
REQ-002 Parameter DATA_W, default 8; width of each IFM byte, the weight and each OFM byte.
REQ-003 Parameter ACC_W, default 24; per-PE signed accumulator width.
REQ-004 Port clk, input, 1; the single clock; all state changes on its rising edge.
REQ-005 Port reset_n, input, 1; reset is synchronous and active-low.
REQ-006 Port IFM, input, NUM_OF_PE*DATA_W; PE i operand is IFM[i*8+:8], signed two's complement.
REQ-007 Port Weight, input, DATA_W; signed weight broadcast to all PEs.
REQ-008 Port OFM, output, NUM_OF_PE*DATA_W; PE i result on OFM[i*8+:8].
REQ-009 Port PE_restart, input, NUM_OF_PE; bit i clears PE i's accumulator.
REQ-010 Port PE_finish, input, NUM_OF_PE; bit i freezes PE i and requests valid.
REQ-011 Port valid, output, NUM_OF_PE; bit i flags PE i's result as final.

Function
REQ-012 Each PE i updates its accumulator acc[i] on every rising clk edge, by priority:
- reset_n=0: clear;
- PE_restart[i]=1: clear;
- PE_finish[i]=1: hold;
- otherwise: acc[i] + sext(IFM_i * Weight).
REQ-013 The product is a full 16-bit signed product, sign-extended to ACC_W; accumulation wraps in two's complement with no overflow flag.
REQ-014 There is no input handshake: a MAC occurs on every non-restart, non-finish cycle, and the operands are the values present at that edge.
REQ-015 Latency: operands sampled at edge N are reflected on OFM after edge N, before edge N+1 (one-cycle MAC, no pipeline).
REQ-016 OFM[i] is combinational from acc[i]; it is valid at any negedge regardless of valid[i].
REQ-017 Without CONV256_RELU_EN, OFM[i] = acc[i] saturated to the signed range -128..127.
REQ-018 valid[i] is registered: valid[i] <= PE_finish[i] & ~PE_restart[i] & reset_n.
REQ-019 valid[i] stays high while PE_finish[i] stays high, and drops on the edge after PE_finish[i] deasserts.
REQ-020 Simultaneous PE_restart[i] and PE_finish[i]: restart wins, giving acc[i]=0 and valid[i]=0.
REQ-021 Restart mid-accumulation discards the partial sum; the next non-restart cycle starts a fresh sum from 0 with that cycle's operands.
REQ-022 PEs are fully independent; per-bit control affects only its own PE.

Reset
REQ-023 With reset_n=0 at a rising edge, all acc = 0 and all valid = 0, so OFM = 0 and valid = 0 after that edge.
REQ-024 Reset overrides PE_restart and PE_finish; asserting it mid-accumulation clears all partial sums on that edge.

Configuration
REQ-025 Macro CONV256_RELU_EN:
- defined: OFM[i] = 0 if acc[i] < 0, else min(acc[i], 127), output range 0..127;
- undefined: signed saturation per REQ-017.
REQ-026 The macro affects only the OFM output mapping; the accumulator, valid and timing are identical in both builds.

Verification
REQ-027 Hold reset_n=0 for 2 cycles with random IFM, Weight and controls -> OFM all 0x00, valid all 0.
REQ-028 Pulse PE_restart all-ones, then 27 cycles of IFM bytes = 0x01 and Weight = 0x02 -> every OFM byte = 0x36 at the following negedge.
REQ-029 After 10 MACs, pulse PE_restart[0] only -> OFM[0] = 0x00 after that edge while other PEs keep accumulating; after 27 more cycles of 1x2, OFM[0] = 0x36.
REQ-030 Saturation, 27 cycles each:
- IFM 0x7F, Weight 0x7F -> OFM = 0x7F (both builds);
- IFM 0x80, Weight 0x01 -> OFM = 0x80 without the macro, 0x00 with it.
REQ-031 Assert PE_finish all-ones for 3 cycles while IFM/Weight keep toggling -> OFM unchanged, valid all-ones from the first edge after assertion, valid all-zero one edge after release.
REQ-032 Assert PE_finish and PE_restart together on PE 5 -> OFM[5] = 0x00 and valid[5] = 0 after that edge.
